// File: rtl/floo_vc_credit_scheduler.sv
// Round-robin credit scheduler: shares one link between NumVirtChannels VCs, one credit counter per VC.
// Latency: 1 cycle, valid_i/data_i to the registered valid_o/data_o/vc_id_o. Optional packet locking via FLOO_VC_SCHED_WORMHOLE_EN.
// Backpressure: ready_o is one-hot or zero and gated by credits; the link itself has none, so credits come back on credit_i.
module floo_vc_credit_scheduler #(
    parameter int unsigned  NumVirtChannels = 2,
    parameter int unsigned  NumCredits      = 4,
    parameter type          flit_t          = logic,
    parameter int unsigned  CntWidth        = $clog2(NumCredits + 1),
    localparam int unsigned VcIdWidth       = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVirtChannels-1:0] valid_i,
    output logic [NumVirtChannels-1:0] ready_o,
    input  flit_t                      data_i [NumVirtChannels],
    input  logic [NumVirtChannels-1:0] last_i,
    output logic                       valid_o,
    output flit_t                      data_o,
    output logic [VcIdWidth-1:0]       vc_id_o,
    input  logic [NumVirtChannels-1:0] credit_i,
    output logic                       credit_err_o
);

    typedef logic [CntWidth-1:0] cnt_t;
    localparam cnt_t MaxCredit = cnt_t'(NumCredits);

    cnt_t                       credit_q [NumVirtChannels];
    cnt_t                       credit_d [NumVirtChannels];
    logic [VcIdWidth-1:0]       ptr_q, ptr_d;
    logic                       valid_q;
    flit_t                      data_q;
    logic [VcIdWidth-1:0]       vc_q;
    logic                       err_q, err_d;

    logic [NumVirtChannels-1:0] eligible;
    logic [NumVirtChannels-1:0] grant;
    logic                       found;
    logic [VcIdWidth-1:0]       win;
    flit_t                      win_data;
    logic                       win_last;

`ifdef FLOO_VC_SCHED_WORMHOLE_EN
    logic                       lock_q, lock_d;
    logic [VcIdWidth-1:0]       lock_vc_q, lock_vc_d;
`else
    logic                       unused_last;
    assign unused_last = ^last_i;
`endif

    always_comb begin
        eligible = '0;
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            eligible[v] = valid_i[v] && (credit_q[v] != '0);
`ifdef FLOO_VC_SCHED_WORMHOLE_EN
            // A packet in flight owns the link until its last flit leaves.
            if (lock_q && (VcIdWidth'(v) != lock_vc_q)) begin
                eligible[v] = 1'b0;
            end
`endif
        end
    end

    // First pass covers [ptr, N-1], second pass wraps around to [0, ptr-1].
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        win      = '0;
        win_data = data_q;
        win_last = 1'b0;
        ptr_d    = ptr_q;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned v = 0; v < NumVirtChannels; v++) begin
                if (!found && eligible[v] && ((pass == 1) || (VcIdWidth'(v) >= ptr_q))) begin
                    found    = 1'b1;
                    grant[v] = 1'b1;
                    win      = VcIdWidth'(v);
                    win_data = data_i[v];
                    win_last = last_i[v];
                    ptr_d    = (v == NumVirtChannels - 1) ? '0 : VcIdWidth'(v + 1);
                end
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            if (grant[v] && !credit_i[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end else if (!grant[v] && credit_i[v]) begin
                if (credit_q[v] == MaxCredit) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end
        end
    end

`ifdef FLOO_VC_SCHED_WORMHOLE_EN
    always_comb begin
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        if (found) begin
            lock_d    = !win_last;
            lock_vc_d = win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned v = 0; v < NumVirtChannels; v++) begin
                credit_q[v] <= MaxCredit;
            end
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
            valid_q  <= found;
            if (found) begin
                data_q <= win_data;
                vc_q   <= win;
            end
        end
    end

    assign ready_o      = rst_ni ? grant : '0;
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign vc_id_o      = vc_q;
    assign credit_err_o = err_q;

endmodule

// File: doc/floo_vc_credit_scheduler.md
Name: floo_vc_credit_scheduler

Overview:
- Credit-based scheduler that shares one physical link between NumVirtChannels virtual channels.
- Sits in front of a cut chain or a router output port.
- Keeps one credit counter per VC, mirroring the downstream buffer space.
- Picks one eligible VC per cycle, round-robin, and drives a registered flit plus its VC id onto the link; the downstream side returns credits.

Parameters:
- NumVirtChannels, 2, number of VCs sharing the link (>=1; 1 means no arbitration, credit logic still active).
- NumCredits, 4, downstream buffer depth per VC; reset value of each credit counter (>=1).
- flit_t, logic, flit payload type.
- CntWidth, $clog2(NumCredits+1), derived width of each credit counter; must not be overridden.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  NumVirtChannels  per-VC flit valid.
- ready_o  output  NumVirtChannels  per-VC accept; one-hot or zero.
- data_i  input  NumVirtChannels x flit_t  per-VC flit.
- last_i  input  NumVirtChannels  per-VC last-flit-of-packet marker; used only with the optional feature.
- valid_o  output  1  link flit valid, registered.
- data_o  output  flit_t  link flit, registered.
- vc_id_o  output  max(1,$clog2(NumVirtChannels))  VC of data_o, registered.
- credit_i  input  NumVirtChannels  per-VC credit return pulse; one credit per asserted bit per cycle.
- credit_err_o  output  1  sticky error flag: credit overflow.

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset values:
  - every credit counter = NumCredits;
  - round-robin pointer = 0;
  - valid_o = 0, data_o = '0, vc_id_o = 0, credit_err_o = 0;
  - ready_o = 0 while in reset.
- Eligibility: VC v is eligible when valid_i[v]=1 and credit[v]>0.
- Arbitration (combinational):
  - Search eligible VCs starting at the pointer, ascending, wrapping at NumVirtChannels-1 -> 0.
  - The first hit wins; ready_o[winner]=1, all other ready_o bits = 0.
  - ready_o may depend on valid_i. valid_i must not depend on ready_o.
- Transfer: a handshake (valid_i[v] & ready_o[v]) at edge N causes, at edge N:
  - valid_o <= 1, data_o <= data_i[v], vc_id_o <= v;
  - pointer <= (v+1) mod NumVirtChannels.
  - Latency is exactly 1 cycle. The link has no backpressure (credit-based), so valid_o is a one-cycle pulse per flit.
- No eligible VC in a cycle: valid_o <= 0; data_o and vc_id_o hold their previous values; pointer unchanged.
- Credit counter update per VC, each cycle:
  - send only: -1;
  - credit_i only: +1;
  - send and credit_i in the same cycle: unchanged.
  - A VC at 0 credits cannot send, so the counter never underflows.
- Credit overflow: a credit_i increment that would exceed NumCredits leaves the counter at NumCredits and sets credit_err_o=1. credit_err_o stays set until reset.
- Starvation bound: a continuously eligible VC is granted within NumVirtChannels cycles.
- Reset mid-operation: all state returns to reset values asynchronously. Flits in flight are lost; the downstream side must be reset in the same domain.

Optional Feature:
- Macro: FLOO_VC_SCHED_WORMHOLE_EN.
- Defined:
  - After a grant to VC v with last_i[v]=0, the scheduler locks to v.
  - While locked, only v may be granted. Other VCs see ready_o=0 even if eligible.
  - If v has no valid flit or no credit, the cycle idles (valid_o=0) and the lock holds.
  - The lock releases on the cycle a flit with last_i[v]=1 is sent; the pointer then advances as normal.
  - Reset clears the lock.
- Not defined: last_i is ignored and every flit is arbitrated independently (flit-level interleaving).

Test Plan:
1. NumVirtChannels=2, NumCredits=4, no credit_i, VC0 valid continuously -> exactly 4 flits with vc_id_o=0 on consecutive cycles, then ready_o[0]=0 and valid_o=0 indefinitely.
2. Both VCs valid continuously, credit_i returned for every flit one cycle after valid_o -> vc_id_o alternates 0,1,0,1,…; no idle cycles after the first.
3. VC0 at 0 credits, in the cycle where credit_i[0]=1 and VC1 also sends -> VC0 counter becomes 1; VC0 is granted on the next cycle if the pointer is at 0, otherwise within 2 cycles.
4. Send on VC1 in the same cycle as credit_i[1]=1 with credit=2 -> counter stays 2; data_o equals data_i[1] one cycle later.
5. credit_i[0]=1 while the VC0 counter is 4 -> counter stays 4; credit_err_o=1 from the next cycle and remains 1 until rst_ni is asserted.
6. With FLOO_VC_SCHED_WORMHOLE_EN: VC0 sends a 3-flit packet (last_i on the third), VC1 valid throughout -> vc_id_o = 0,0,0,1. Without the macro -> 0,1,0,1,0.
